// File: rtl/fifo_fwft_dp_ram.sv
// fifo_fwft_dp_ram
// Synchronous FIFO built on a simple dual-port RAM with a registered read
// port. It supports two read modes selected by FWFT:
//   FWFT=0 : standard mode. A read request returns the head word one cycle later.
//   FWFT=1 : first-word-fall-through. The head word is prefetched into rd_data.
//            rd_en acts as a pop acknowledge.
//
// Handshake semantics:
//   A write transfers when wr_en && !full.
//   FWFT=0: a read transfers when rd_en && !empty. rd_valid marks the returned
//           word for exactly one cycle.
//   FWFT=1: a pop transfers when rd_en && rd_valid, like a valid/ready sink where
//           rd_en is "ready". rd_valid/rd_data remain stable until popped.
//   Requests that cannot transfer are dropped, and they set the sticky
//   overflow/underflow flag.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   wr_en, wr_data        write request and word
//   rd_en                 read request (FWFT=0) / pop acknowledge (FWFT=1)
//   rd_data, rd_valid     registered read word and its valid flag
//   full, empty           occupancy status
//   almost_full/_empty    level compared against live thresholds
//   level                 stored word count, 0..DEPTH
//   af_thresh, ae_thresh  almost-flag thresholds
//   overflow, underflow   sticky error flags, cleared by err_clear
module fifo_fwft_dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int FWFT       = 0,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         level,
  input  logic [LW-1:0]         af_thresh,
  input  logic [LW-1:0]         ae_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clear
);

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam bit FWFT_MODE = (FWFT != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]         wr_ptr;
  logic [LW-1:0]         rd_ptr;

  logic wr_acc;
  logic rd_acc;
  logic ram_has_word;
  logic fetch;

  assign full  = (level == DEPTH_L);
  // In FWFT mode, "available" means a word is sitting in rd_data. The count
  // in level also includes that prefetched word.
  assign empty = FWFT_MODE ? !rd_valid : (level == '0);

  assign almost_full  = (level >= af_thresh);
  assign almost_empty = (level <= ae_thresh);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // In FWFT mode, rd_ptr is a fetch pointer. The RAM holds unfetched words
  // whenever the pointers differ, including in the wrap bit.
  assign ram_has_word = (wr_ptr != rd_ptr);

  // FWFT mode refills the output register when it is empty or is being popped.
  // In standard mode, the RAM is read only on an accepted read request.
  assign fetch = FWFT_MODE ? (ram_has_word && (!rd_valid || rd_acc)) : rd_acc;

  // The write port is never at the same address as an active read. A fetch
  // needs unfetched words, so the addresses collide only when the RAM holds
  // DEPTH words. In that case full blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + LW'(1);
      end

      if (fetch) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + LW'(1);
      end

      if (FWFT_MODE) begin
        if (fetch) begin
          rd_valid <= 1'b1;
        end else if (rd_acc) begin
          rd_valid <= 1'b0;
        end
      end else begin
        rd_valid <= rd_acc;
      end

      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      // A new error in the same cycle as err_clear wins.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clear) begin
        overflow <= 1'b0;
      end

      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clear) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fwft_dp_ram.sv
// Testbench for fifo_fwft_dp_ram.
// It uses two instances with DEPTH=4 and DATA_WIDTH=8: u_std (FWFT=0) and
// u_fwft (FWFT=1).
//   - Inputs are driven 1 time unit after each rising edge.
//   - Written words are pushed into a per-instance expected queue.
//   - Monitors on the falling edge pop a queue entry and compare it with
//     rd_data when a word is presented (standard) or popped (FWFT).
//   - Flag and level checks are directed, with hand-computed values.
module tb_fifo_fwft_dp_ram;

  localparam int DW = 8;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [LW-1:0] af_thresh = 3'd3;
  logic [LW-1:0] ae_thresh = 3'd1;

  logic          wr_en0 = 0, rd_en0 = 0, err_clear0 = 0;
  logic [DW-1:0] wr_data0 = '0;
  logic [DW-1:0] rd_data0;
  logic          rd_valid0, full0, empty0, almost_full0, almost_empty0, overflow0, underflow0;
  logic [LW-1:0] level0;

  logic          wr_en1 = 0, rd_en1 = 0, err_clear1 = 0;
  logic [DW-1:0] wr_data1 = '0;
  logic [DW-1:0] rd_data1;
  logic          rd_valid1, full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [LW-1:0] level1;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] e0, e1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] data_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] data_b [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
  // Expected almost flags at levels 0..4, with af_thresh=3 and ae_thresh=1.
  bit ae_tab [5] = '{1, 1, 0, 0, 0};
  bit af_tab [5] = '{0, 0, 0, 1, 1};

  fifo_fwft_dp_ram #(.DATA_WIDTH(DW), .DEPTH(4), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(almost_full0), .almost_empty(almost_empty0), .level(level0),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(overflow0),
    .underflow(underflow0), .err_clear(err_clear0)
  );

  fifo_fwft_dp_ram #(.DATA_WIDTH(DW), .DEPTH(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(almost_full1), .almost_empty(almost_empty1), .level(level1),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .overflow(overflow1),
    .underflow(underflow1), .err_clear(err_clear1)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Standard-mode monitor: a word is presented whenever rd_valid is high.
  always @(negedge clk) begin
    if (!reset && rd_valid0) begin
      if (exp_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data_std: got %0h expected no word", rd_data0);
      end else begin
        e0 = exp_q0.pop_front();
        check("rd_data_std", rd_data0, e0);
      end
    end
  end

  // FWFT monitor: the head word is consumed when a pop is accepted.
  always @(negedge clk) begin
    if (!reset && rd_valid1 && rd_en1) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data_fwft: got %0h expected no word", rd_data1);
      end else begin
        e1 = exp_q1.pop_front();
        check("rd_data_fwft", rd_data1, e1);
      end
    end
  end

  initial begin
    // Reset
    tick();
    tick();
    reset = 1'b0;
    check("rst_level0", level0, 0);
    check("rst_empty0", empty0, 1);
    check("rst_full0", full0, 0);
    check("rst_rd_valid0", rd_valid0, 0);
    check("rst_rd_data0", rd_data0, 0);
    check("rst_almost_empty0", almost_empty0, 1);
    check("rst_almost_full0", almost_full0, 0);
    check("rst_overflow0", overflow0, 0);
    check("rst_underflow0", underflow0, 0);
    check("rst_level1", level1, 0);
    check("rst_empty1", empty1, 1);
    check("rst_rd_valid1", rd_valid1, 0);
    af_thresh = 3'd0;
    #1;
    check("rst_af_thresh0", almost_full0, 1);
    af_thresh = 3'd3;
    #1;

    // Standard mode: fill, overflow, drain
    for (int i = 0; i < 4; i++) begin
      wr_en0 = 1'b1;
      wr_data0 = data_a[i];
      exp_q0.push_back(data_a[i]);
      tick();
      check("fill_level0", level0, i + 1);
      check("fill_almost_empty0", almost_empty0, ae_tab[i+1]);
      check("fill_almost_full0", almost_full0, af_tab[i+1]);
    end
    check("fill_full0", full0, 1);
    wr_data0 = 8'h55;
    tick();
    wr_en0 = 1'b0;
    check("ovf_overflow0", overflow0, 1);
    check("ovf_level0", level0, 4);
    rd_en0 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_en0 = 1'b0;
    check("drain_level0", level0, 0);
    check("drain_empty0", empty0, 1);
    tick();
    check("drain_rd_valid0", rd_valid0, 0);
    check("hold_rd_data0", rd_data0, 8'h44);
    check("drain_underflow0", underflow0, 0);
    err_clear0 = 1'b1;
    tick();
    err_clear0 = 1'b0;
    check("clr_overflow0", overflow0, 0);

    // Standard mode: write and read together on an empty FIFO
    wr_en0 = 1'b1;
    rd_en0 = 1'b1;
    wr_data0 = 8'h66;
    exp_q0.push_back(8'h66);
    tick();
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    check("wr_rd_empty_underflow0", underflow0, 1);
    check("wr_rd_empty_level0", level0, 1);
    check("wr_rd_empty_rd_valid0", rd_valid0, 0);
    af_thresh = 3'd1;
    #1;
    check("live_af_thresh_hi0", almost_full0, 1);
    af_thresh = 3'd3;
    #1;
    check("live_af_thresh_lo0", almost_full0, 0);
    err_clear0 = 1'b1;
    tick();
    err_clear0 = 1'b0;
    check("clr_underflow0", underflow0, 0);
    rd_en0 = 1'b1;
    tick();
    rd_en0 = 1'b0;
    check("single_read_level0", level0, 0);
    tick();

    // FWFT: single-word latency and pop
    wr_en1 = 1'b1;
    wr_data1 = 8'hA5;
    exp_q1.push_back(8'hA5);
    tick();
    wr_en1 = 1'b0;
    check("fwft_c1_rd_valid1", rd_valid1, 0);
    check("fwft_c1_level1", level1, 1);
    check("fwft_c1_empty1", empty1, 1);
    tick();
    check("fwft_c2_rd_valid1", rd_valid1, 1);
    check("fwft_c2_rd_data1", rd_data1, 8'hA5);
    check("fwft_c2_empty1", empty1, 0);
    rd_en1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    check("fwft_pop_rd_valid1", rd_valid1, 0);
    check("fwft_pop_empty1", empty1, 1);
    check("fwft_pop_level1", level1, 0);

    // FWFT: fill, overflow, then full with simultaneous read and write
    for (int i = 0; i < 4; i++) begin
      wr_en1 = 1'b1;
      wr_data1 = data_b[i];
      exp_q1.push_back(data_b[i]);
      tick();
    end
    check("fwft_fill_full1", full1, 1);
    check("fwft_fill_level1", level1, 4);
    wr_data1 = 8'h55;
    tick();
    wr_en1 = 1'b0;
    check("fwft_ovf_overflow1", overflow1, 1);
    check("fwft_ovf_level1", level1, 4);
    err_clear1 = 1'b1;
    tick();
    err_clear1 = 1'b0;
    check("fwft_clr_overflow1", overflow1, 0);
    wr_en1 = 1'b1;
    wr_data1 = 8'h77;
    rd_en1 = 1'b1;
    check("fwft_burst_rd_valid1", rd_valid1, 1);
    tick();
    wr_en1 = 1'b0;
    check("fwft_full_rw_overflow1", overflow1, 1);
    check("fwft_full_rw_level1", level1, 3);
    for (int i = 0; i < 3; i++) begin
      check("fwft_burst_rd_valid1", rd_valid1, 1);
      tick();
    end
    rd_en1 = 1'b0;
    check("fwft_burst_empty1", empty1, 1);
    check("fwft_burst_level1", level1, 0);
    rd_en1 = 1'b1;
    err_clear1 = 1'b1;
    tick();
    rd_en1 = 1'b0;
    err_clear1 = 1'b0;
    check("fwft_err_wins_underflow1", underflow1, 1);
    err_clear1 = 1'b1;
    tick();
    err_clear1 = 1'b0;
    check("fwft_clr_underflow1", underflow1, 0);

    // Standard mode: interleaved traffic through the pointer wrap, then reset
    for (int i = 0; i < 10; i++) begin
      wr_en0 = 1'b1;
      rd_en0 = 1'b1;
      wr_data0 = 8'h70 + 8'(i);
      exp_q0.push_back(8'h70 + 8'(i));
      tick();
    end
    rd_en0 = 1'b0;
    wr_data0 = 8'h7A;
    exp_q0.push_back(8'h7A);
    tick();
    check("wrap_level0", level0, 2);
    check("wrap_underflow0", underflow0, 1);
    reset = 1'b1;
    wr_en0 = 1'b1;
    rd_en0 = 1'b1;
    err_clear0 = 1'b1;
    wr_data0 = 8'h99;
    tick();
    reset = 1'b0;
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    err_clear0 = 1'b0;
    exp_q0.delete();
    check("mid_rst_level0", level0, 0);
    check("mid_rst_empty0", empty0, 1);
    check("mid_rst_rd_valid0", rd_valid0, 0);
    check("mid_rst_full0", full0, 0);
    check("mid_rst_underflow0", underflow0, 0);
    check("mid_rst_overflow0", overflow0, 0);
    tick();
    check("fwft_queue_drained", exp_q1.size(), 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_fwft_dp_ram.md
FIFO_FWFT_DP_RAM -- requirements
Module: fifo_fwft_dp_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter DEPTH, default 256, capacity in words; power of 2, >=4.
REQ-003 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through.
REQ-004 Localparam LW = $clog2(DEPTH)+1, width of level and thresholds.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_data  in  DATA_WIDTH  write word.
REQ-009 rd_en  in  1  read request (FWFT=0) / pop acknowledge (FWFT=1).
REQ-010 rd_data  out  DATA_WIDTH  read word, registered.
REQ-011 rd_valid  out  1  rd_data holds a valid word.
REQ-012 full  out  1  level == DEPTH.
REQ-013 empty  out  1  no word available to read.
REQ-014 almost_full  out  1  level >= af_thresh.
REQ-015 almost_empty  out  1  level <= ae_thresh.
REQ-016 level  out  LW  stored word count, 0..DEPTH.
REQ-017 af_thresh, ae_thresh  in  LW each  live almost-flag thresholds.
REQ-018 overflow, underflow  out  1 each  sticky error flags.
REQ-019 err_clear  in  1  clears sticky error flags.

Function
REQ-020 Storage SHALL be a simple dual-port RAM with synchronous read; pointers LW bits wide, low LW-1 bits address, MSB wrap bit.
REQ-021 Write SHALL be accepted iff wr_en && !full; accepted word stored at wr_ptr, wr_ptr increments modulo 2*DEPTH.
REQ-022 wr_en && full SHALL drop the word, leave state unchanged, set overflow next cycle.
REQ-023 level SHALL update one cycle after acceptance: +1 write only, -1 read/pop only, unchanged for both or neither.
REQ-024 FWFT=0: read accepted iff rd_en && !empty; rd_data = head word and rd_valid=1 in cycle c+1; rd_valid=0 otherwise; rd_data holds last value when no read.
REQ-025 FWFT=0: empty SHALL equal (level==0).
REQ-026 FWFT=1: rd_valid=1 SHALL mean rd_data shows head word without rd_en; empty SHALL equal !rd_valid.
REQ-027 FWFT=1: wr_en in cycle c into empty FIFO SHALL give rd_valid=1, rd_data=word in cycle c+2.
REQ-028 FWFT=1: pop accepted iff rd_en && rd_valid; next word SHALL be presented in cycle c+1 with no bubble if written before cycle c, else rd_valid=0 for at most one cycle.
REQ-029 rd_en with no word available (empty in either mode) SHALL be ignored and set underflow next cycle.
REQ-030 Simultaneous: full+rd+wr -> read/pop accepted, write rejected, overflow set; empty+rd+wr -> write accepted, read rejected, underflow set; otherwise both accepted, level unchanged.
REQ-031 Pointer wrap SHALL be seamless: data order preserved across address DEPTH-1 -> 0.
REQ-032 almost_full/almost_empty SHALL be combinational on registered level and live thresholds; threshold changes take effect same cycle.
REQ-033 err_clear SHALL clear both sticky flags next cycle; a new error in the same cycle wins (flag set).
REQ-034 level SHALL never exceed DEPTH nor go below 0.

Reset
REQ-035 reset SHALL, on the next edge, zero pointers, level, rd_data, rd_valid, overflow, underflow; full=0, empty=1; RAM contents not cleared.
REQ-036 After reset almost_empty=1; almost_full=1 only if af_thresh==0.
REQ-037 reset mid-operation SHALL take priority over all concurrent wr_en/rd_en/err_clear; stored words discarded.

Verification (DEPTH=4, DATA_WIDTH=8)
REQ-038 FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, level=4; 5th write 0x55 -> overflow=1, data dropped; 4 reads -> 0x11..0x44 each one cycle after rd_en, then empty=1.
REQ-039 FWFT=1: single write 0xA5 at cycle c -> rd_valid=1, rd_data=0xA5 at c+2 with rd_en=0; rd_en -> rd_valid=0, empty=1, level=0.
REQ-040 FWFT=1: fill 4 words, hold rd_en 4 cycles -> 4 consecutive valid words, no bubble, in order.
REQ-041 Empty FIFO, wr_en+rd_en same cycle -> write accepted, underflow=1, level=1; err_clear -> underflow=0.
REQ-042 af_thresh=3, ae_thresh=1: levels 0..4 -> almost_empty 1,1,0,0,0; almost_full 0,0,0,1,1.
REQ-043 10 writes/reads interleaved through wrap, reset asserted at level 2 -> next cycle level=0, empty=1, rd_valid=0, flags 0.
